// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box tables and FSM state type.
//   AES_BLOCK_W : state width in bits
//   AES_BYTES   : bytes per state
//   SBOX_FWD    : forward S-box, entry x at bits [8*x +: 8] (entry 0 leftmost)
//   SBOX_INV    : inverse S-box, same layout
//   aes_state_t : SubBytes iterator FSM states
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_t;

  localparam logic [0:2047] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: single-byte AES S-box lookup, purely combinational.
//   din  : byte to substitute
//   inv  : 1 selects the inverse S-box (only when AES_SUB_BYTES_INV_EN is defined)
//   dout : substituted byte
// Macro AES_SUB_BYTES_INV_EN: when undefined only the forward table is built
// and inv is ignored.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  logic [10:0] base;
  assign base = {din, 3'b000};

`ifdef AES_SUB_BYTES_INV_EN
  assign dout = inv ? SBOX_INV[base +: 8] : SBOX_FWD[base +: 8];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign dout = SBOX_FWD[base +: 8];
`endif

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// aes_sub_bytes_iter: iterative AES SubBytes, BYTES_PER_CYCLE lookups per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake; in_block and inv captured on it
//   in_block [0:127]     : state, byte i at [8*i +: 8], byte 0 leftmost
//   inv                  : inverse S-box select (AES_SUB_BYTES_INV_EN only)
//   out_valid / out_ready: output handshake
//   out_block [0:127]    : substituted state, same byte order
// Parameter BYTES_PER_CYCLE: 4, 8 or 16.
// Macro AES_SUB_BYTES_INV_EN: enables the inverse S-box (see aes_sbox).
//
// state | meaning
// IDLE  | waiting for an input, in_ready=1
// BUSY  | substituting one slice per cycle into out_block
// DONE  | out_valid=1, out_block held; in_ready follows out_ready
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_BLOCK_W-1] in_block,
  input  logic                   inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_BLOCK_W-1] out_block
);

  localparam logic [3:0] IDX_STEP = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] IDX_LAST = 4'(AES_BYTES - BYTES_PER_CYCLE);

  aes_state_t             state;
  logic [3:0]             idx;
  logic [0:AES_BLOCK_W-1] blk_q;
  logic                   inv_q;

  logic [6:0] sb_base [BYTES_PER_CYCLE];
  logic [7:0] sb_in   [BYTES_PER_CYCLE];
  logic [7:0] sb_out  [BYTES_PER_CYCLE];

  for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
    assign sb_base[k] = {idx + 4'(k), 3'b000};
    assign sb_in[k]   = blk_q[sb_base[k] +: 8];
    aes_sbox u_sbox (
      .din  (sb_in[k]),
      .inv  (inv_q),
      .dout (sb_out[k])
    );
  end

  // DONE hands over and takes the next block in one edge.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      blk_q     <= '0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      out_block <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            blk_q <= in_block;
            inv_q <= inv;
            idx   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            out_block[sb_base[k] +: 8] <= sb_out[k];
          end
          // Hold idx on the last slice so it never wraps.
          if (idx == IDX_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              blk_q <= in_block;
              inv_q <= inv;
              idx   <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// tb_aes_sub_bytes_iter: scoreboard bench for aes_sub_bytes_iter.
// Three instances (BYTES_PER_CYCLE 4, 16, 8) share clock and reset.
// The reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_sub_bytes_iter;

`ifdef AES_SUB_BYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [0:127] VEC_A = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] VEC_B = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic clk;
  logic rst_n;
  logic         dv_in_valid  [3];
  logic         dv_in_ready  [3];
  logic [0:127] dv_in_block  [3];
  logic         dv_inv       [3];
  logic         dv_out_valid [3];
  logic         dv_out_ready [3];
  logic [0:127] dv_out_block [3];

  function automatic int bpc_of(int g);
    return (g == 0) ? 4 : ((g == 1) ? 16 : 8);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BPC = (g == 0) ? 4 : ((g == 1) ? 16 : 8);
    aes_sub_bytes_iter #(.BYTES_PER_CYCLE(BPC)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (dv_in_valid[g]),
      .in_ready  (dv_in_ready[g]),
      .in_block  (dv_in_block[g]),
      .inv       (dv_inv[g]),
      .out_valid (dv_out_valid[g]),
      .out_ready (dv_out_ready[g]),
      .out_block (dv_out_block[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_or  = 1'b0;

  typedef struct {
    int           d;
    logic [0:127] data;
    int           hs;
  } exp_t;
  exp_t sb[$];

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_math(logic [7:0] x);
    logic [7:0] y = 8'h00;
    if (x != 8'h00) begin
      y = 8'h01;
      for (int i = 0; i < 254; i++) y = gmul(y, x);
    end
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:127] model(logic [0:127] blk, logic iv);
    logic [0:127] r;
    logic         use_inv = iv & INV_EN;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = use_inv ? inv_tab[blk[8*i +: 8]] : fwd_tab[blk[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency on each out_valid rise, data on each output handshake.
  logic ov_prev [3] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst_n && dv_out_valid[g] && !ov_prev[g]) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 128'(g), 128'hffff);
        end else begin
          chk("dut_id", 128'(g), 128'(sb[0].d));
          chk("latency", 128'(cyc - sb[0].hs), 128'(16 / bpc_of(g)));
        end
      end
      if (rst_n && dv_out_valid[g] && dv_out_ready[g] && sb.size() != 0) begin
        chk("out_block", dv_out_block[g], sb[0].data);
        void'(sb.pop_front());
      end
      ov_prev[g] = rst_n ? dv_out_valid[g] : 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_or)
        for (int g = 0; g < 3; g++) dv_out_ready[g] = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input int d, input logic [0:127] blk, input logic iv,
                      input logic [0:127] exp, output int hs);
    bit ok = 1'b0;
    int n  = 0;
    dv_in_block[d] = blk;
    dv_inv[d]      = iv;
    dv_in_valid[d] = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (dv_in_ready[d]) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      chk("handshake_timeout", 128'(d), 128'hffff);
      hs = -1;
      dv_in_valid[d] = 1'b0;
    end else begin
      hs = cyc + 1;
      sb.push_back('{d, exp, hs});
      @(posedge clk);
      #1;
      dv_in_valid[d] = 1'b0;
      dv_in_block[d] = {$urandom, $urandom, $urandom, $urandom};
      dv_inv[d]      = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 128'(sb.size()), 128'h0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:127] blk;
    logic [0:127] exp;
    logic         iv;
    int           hs, hs2, rel;
    bit           seen;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:127] blk;
    logic [0:127] exp;
    logic [0:127] inv_exp;
    logic         iv;
    int           hs, hs2, rel, n;

    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) begin
      dv_in_valid[g]  = 1'b0;
      dv_in_block[g]  = '0;
      dv_inv[g]       = 1'b0;
      dv_out_ready[g] = 1'b1;
    end
    for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_math(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_in_ready", 128'(dv_in_ready[g]), 128'h1);
      chk("rst_out_valid", 128'(dv_out_valid[g]), 128'h0);
      chk("rst_out_block", dv_out_block[g], 128'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;

    // Forward vector, accepted on the first edge after reset release.
    send(0, VEC_A, 1'b0, VEC_B, hs);
    chk("accept_after_reset", 128'(hs), 128'(rel + 1));
    drain();

    // Inverse vector.
    inv_exp = INV_EN ? VEC_A : model(VEC_B, 1'b0);
    send(0, VEC_B, 1'b1, inv_exp, hs);
    drain();

    // Backpressure: output held for 10 cycles, then exactly one handshake.
    dv_out_ready[0] = 1'b0;
    blk = {$urandom, $urandom, $urandom, $urandom};
    exp = model(blk, 1'b0);
    send(0, blk, 1'b0, exp, hs);
    n = 0;
    while (!dv_out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 128'(dv_out_valid[0]), 128'h1);
      chk("bp_out_block", dv_out_block[0], exp);
      chk("bp_in_ready", 128'(dv_in_ready[0]), 128'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 dv_out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_single_handshake", 128'(dv_out_valid[0]), 128'h0);
    drain();

    // Back-to-back: second block taken in the DONE cycle of the first,
    // so handshakes are spaced by latency plus that one DONE cycle.
    send(0, {16{8'h00}}, 1'b0, {16{8'h63}}, hs);
    send(0, {16{8'hff}}, 1'b0, {16{8'h16}}, hs2);
    chk("b2b_spacing", 128'(hs2 - hs), 128'(16 / bpc_of(0) + 1));
    drain();

    // Reset in the second BUSY cycle discards the block.
    blk = {$urandom, $urandom, $urandom, $urandom};
    send(0, blk, 1'b0, model(blk, 1'b0), hs);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(dv_out_valid[0]), 128'h0);
    chk("midrst_out_block", dv_out_block[0], 128'h0);
    chk("midrst_in_ready", 128'(dv_in_ready[0]), 128'h1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    send(0, {16{8'h53}}, 1'b0, {16{8'hed}}, hs);
    chk("midrst_accept", 128'(hs), 128'(rel + 1));
    drain();

    // Random blocks, random inv, random backpressure and idle gaps.
    rand_or = 1'b1;
    for (int i = 0; i < 24; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      iv  = 1'($urandom_range(0, 1));
      send(0, blk, iv, model(blk, iv), hs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_or = 1'b0;
    for (int g = 0; g < 3; g++) dv_out_ready[g] = 1'b1;
    drain();

    // Wider datapaths: same vectors, shorter latency.
    for (int d = 1; d < 3; d++) begin
      send(d, VEC_A, 1'b0, VEC_B, hs);
      drain();
      send(d, VEC_B, 1'b1, inv_exp, hs);
      drain();
      rand_or = 1'b1;
      for (int i = 0; i < 6; i++) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        iv  = 1'($urandom_range(0, 1));
        send(d, blk, iv, model(blk, iv), hs);
      end
      rand_or = 1'b0;
      for (int g = 0; g < 3; g++) dv_out_ready[g] = 1'b1;
      drain();
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
